// File: rtl/actor_responder_pkg.sv
// Shared trigger types: invocation result codes and the responder state encoding.
package actor_responder_pkg;

   localparam logic [31:0] EXECUTED    = 32'h0000_0001;
   localparam logic [31:0] WAIT_INPUT  = 32'h0000_0002;
   localparam logic [31:0] WAIT_OUTPUT = 32'h0000_0003;

   typedef enum logic [1:0] {
      RSP_IDLE = 2'd0,
      RSP_XFER = 2'd1,
      RSP_DONE = 2'd2
   } responder_state_t;

endpackage

// File: rtl/actor_responder.sv
// Trigger-protocol responder: per ap_start, moves up to MAX_BURST tokens input->output, then reports a result code.
// Optional ACTOR_RESPONDER_STATS_EN adds a saturating tokens_total output.
module actor_responder
   import actor_responder_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned MAX_BURST  = 16,
   parameter int unsigned CNT_W      = $clog2(MAX_BURST + 1)
) (
   input  logic                  ap_clk,
   input  logic                  ap_rst,
   input  logic                  ap_start,
   output logic                  ap_done,
   output logic                  ap_ready,
   output logic                  ap_idle,
   output logic [31:0]           ap_return,
   input  logic [DATA_WIDTH-1:0] in_dout,
   input  logic                  in_empty_n,
   output logic                  in_read,
   output logic [DATA_WIDTH-1:0] out_din,
   input  logic                  out_full_n,
   output logic                  out_write,
   output logic                  launch_predicate
`ifdef ACTOR_RESPONDER_STATS_EN
   ,
   output logic [31:0]           tokens_total
`endif
);

   responder_state_t state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [31:0]      ret_q, ret_d;
   logic             move;

   assign launch_predicate = in_empty_n & out_full_n;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ret_d   = ret_q;
      move    = 1'b0;
      unique case (state_q)
         RSP_IDLE: begin
            if (ap_start) begin
               state_d = RSP_XFER;
               cnt_d   = '0;
            end
         end
         RSP_XFER: begin
            if (launch_predicate) begin
               move  = 1'b1;
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_q == CNT_W'(MAX_BURST - 1)) begin
                  state_d = RSP_DONE;
                  ret_d   = EXECUTED;
               end
            end else begin
               state_d = RSP_DONE;
               // Input starvation takes precedence when both sides block.
               if (cnt_q != '0) begin
                  ret_d = EXECUTED;
               end else if (!in_empty_n) begin
                  ret_d = WAIT_INPUT;
               end else begin
                  ret_d = WAIT_OUTPUT;
               end
            end
         end
         RSP_DONE: state_d = RSP_IDLE;
         default:  state_d = RSP_IDLE;
      endcase
   end

   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         state_q <= RSP_IDLE;
         cnt_q   <= '0;
         ret_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ret_q   <= ret_d;
      end
   end

   // Reset suppresses the pop in the very cycle it is asserted, so an aborted burst moves nothing more.
   assign in_read   = move & ~ap_rst;
   assign out_write = move & ~ap_rst;
   assign out_din   = in_dout;

   assign ap_done   = (state_q == RSP_DONE);
   assign ap_ready  = ap_done;
   assign ap_idle   = (state_q == RSP_IDLE);
   assign ap_return = ret_q;

`ifdef ACTOR_RESPONDER_STATS_EN
   logic [31:0] total_q, total_d;

   always_comb begin
      total_d = total_q;
      if (out_write && (total_q != '1)) begin
         total_d = total_q + 32'd1;
      end
   end

   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         total_q <= '0;
      end else begin
         total_q <= total_d;
      end
   end

   assign tokens_total = total_q;
`endif

endmodule

// File: tb/tb_actor_responder.sv
// Directed, table-driven bench for actor_responder with a simple input-FIFO model.
module tb_actor_responder;

   logic        ap_clk = 1'b0;
   logic        ap_rst = 1'b1;
   logic        ap_start = 1'b0;
   logic        ap_done, ap_ready, ap_idle;
   logic [31:0] ap_return;
   logic [31:0] in_dout;
   logic        in_empty_n;
   logic        in_read;
   logic [31:0] out_din;
   logic        out_full_n = 1'b1;
   logic        out_write;
   logic        launch_predicate;
`ifdef ACTOR_RESPONDER_STATS_EN
   logic [31:0] tokens_total;
`endif

   localparam logic [31:0] R_EXEC  = 32'h1;
   localparam logic [31:0] R_WIN   = 32'h2;
   localparam logic [31:0] R_WOUT  = 32'h3;

   actor_responder #(.DATA_WIDTH(32), .MAX_BURST(16)) dut (
      .ap_clk(ap_clk), .ap_rst(ap_rst), .ap_start(ap_start),
      .ap_done(ap_done), .ap_ready(ap_ready), .ap_idle(ap_idle), .ap_return(ap_return),
      .in_dout(in_dout), .in_empty_n(in_empty_n), .in_read(in_read),
      .out_din(out_din), .out_full_n(out_full_n), .out_write(out_write),
      .launch_predicate(launch_predicate)
`ifdef ACTOR_RESPONDER_STATS_EN
      , .tokens_total(tokens_total)
`endif
   );

   always #5 ap_clk = ~ap_clk;

   // Input FIFO model: tok[rd_ptr..wr_ptr-1] are queued.
   logic [31:0] tok [0:255];
   int          rd_ptr = 0;
   int          wr_ptr = 0;
   logic [31:0] next_val = 32'hA;

   always_comb begin
      in_empty_n = (rd_ptr < wr_ptr);
      in_dout    = tok[rd_ptr[7:0]];
   end

   always @(posedge ap_clk) begin
      if (in_read) rd_ptr <= rd_ptr + 1;
   end

   int checks = 0;
   int failures = 0;
   int exp_total = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", name, got, exp);
      end
   endtask

   task automatic push(input int n);
      for (int i = 0; i < n; i++) begin
         tok[wr_ptr[7:0]] = next_val;
         next_val = next_val + 32'd1;
         wr_ptr++;
      end
   endtask

   // Called #1 after a rising edge with the DUT idle.
   task automatic run(input string nm, input int add, input bit fulln, input int drop_after,
                      input int exp_moves, input int exp_done, input logic [31:0] exp_ret);
      int q_before, rd0, moves, done_cyc, done_cnt, order_bad, idle_bad;
      logic [31:0] ret_seen;
      bit exp_idle;
      q_before = wr_ptr - rd_ptr;
      rd0 = rd_ptr;
      push(add);
      out_full_n = fulln;
      moves = 0; done_cyc = -1; done_cnt = 0; order_bad = 0; idle_bad = 0; ret_seen = '0;
      ap_start = 1'b1;
      @(posedge ap_clk); #1;
      ap_start = 1'b0;
      for (int c = 1; c <= 60; c++) begin
         @(negedge ap_clk);
         if (in_read !== out_write) order_bad++;
         if (out_write === 1'b1) begin
            if (out_din !== tok[(rd0 + moves) % 256] || c != moves + 1) order_bad++;
            moves++;
         end
         if (ap_done === 1'b1) begin
            done_cnt++;
            if (done_cyc < 0) done_cyc = c;
            ret_seen = ap_return;
            if (ap_ready !== 1'b1) order_bad++;
         end
         exp_idle = (done_cyc >= 0 && c > done_cyc);
         if (ap_idle !== exp_idle) idle_bad++;
         if (done_cyc >= 0 && c > done_cyc) begin
            check({nm, "_ret_held"}, ap_return, exp_ret);
            @(posedge ap_clk); #1;
            break;
         end
         @(posedge ap_clk); #1;
         if (drop_after >= 0 && moves == drop_after) out_full_n = 1'b0;
      end
      if (done_cyc < 0) check({nm, "_done_timeout"}, 32'd0, 32'd1);
      check({nm, "_moves"}, moves, exp_moves);
      check({nm, "_done_cycle"}, done_cyc, exp_done);
      check({nm, "_done_pulses"}, done_cnt, 1);
      check({nm, "_return"}, ret_seen, exp_ret);
      check({nm, "_order"}, order_bad, 0);
      check({nm, "_idle"}, idle_bad, 0);
      check({nm, "_left"}, wr_ptr - rd_ptr, q_before + add - exp_moves);
      exp_total += exp_moves;
`ifdef ACTOR_RESPONDER_STATS_EN
      check({nm, "_tokens_total"}, tokens_total, exp_total);
`endif
   endtask

   typedef struct {
      string       nm;
      int          add;
      bit          fulln;
      int          moves;
      int          done_c;
      logic [31:0] ret;
   } vec_t;

   vec_t vecs [7];

   initial begin
      int mv, extra_done, extra_read;
      vecs[0] = '{"three_tok",   3,  1'b1, 3,  5,  R_EXEC};
      vecs[1] = '{"empty_in",    0,  1'b1, 0,  2,  R_WIN};
      vecs[2] = '{"both_block",  0,  1'b0, 0,  2,  R_WIN};
      vecs[3] = '{"burst_max",   20, 1'b1, 16, 17, R_EXEC};
      vecs[4] = '{"burst_rest",  0,  1'b1, 4,  6,  R_EXEC};
      vecs[5] = '{"out_full",    2,  1'b0, 0,  2,  R_WOUT};
      vecs[6] = '{"drain_two",   0,  1'b1, 2,  4,  R_EXEC};

      repeat (3) @(posedge ap_clk);
      #1;
      @(negedge ap_clk);
      check("rst_idle", ap_idle, 1);
      check("rst_done", ap_done, 0);
      check("rst_ready", ap_ready, 0);
      check("rst_return", ap_return, 0);
      check("rst_in_read", in_read, 0);
      check("rst_out_write", out_write, 0);
`ifdef ACTOR_RESPONDER_STATS_EN
      check("rst_tokens_total", tokens_total, 0);
`endif
      @(posedge ap_clk); #1;
      ap_rst = 1'b0;
      @(posedge ap_clk); #1;

      for (int i = 0; i < 7; i++) begin
         run(vecs[i].nm, vecs[i].add, vecs[i].fulln, -1, vecs[i].moves, vecs[i].done_c, vecs[i].ret);
      end

      // Output backpressure after two moves ends the burst with three tokens left queued.
      run("stall_mid", 5, 1'b1, 2, 2, 4, R_EXEC);
      run("stall_drain", 0, 1'b1, -1, 3, 5, R_EXEC);

      // Reset during cycle 3 of an 8-token burst.
      push(8);
      out_full_n = 1'b1;
      mv = 0;
      ap_start = 1'b1;
      @(posedge ap_clk); #1;
      ap_start = 1'b0;
      for (int c = 1; c <= 2; c++) begin
         @(negedge ap_clk);
         if (out_write === 1'b1) mv++;
         @(posedge ap_clk); #1;
      end
      ap_rst = 1'b1;
      @(negedge ap_clk);
      check("abort_no_read_in_rst", in_read, 0);
      if (out_write === 1'b1) mv++;
      @(posedge ap_clk); #1;
      ap_rst = 1'b0;
      extra_done = 0; extra_read = 0;
      @(negedge ap_clk);
      check("abort_idle", ap_idle, 1);
      check("abort_return", ap_return, 0);
      for (int c = 0; c < 6; c++) begin
         if (ap_done === 1'b1) extra_done++;
         if (in_read === 1'b1) extra_read++;
         @(negedge ap_clk);
      end
      check("abort_no_done", extra_done, 0);
      check("abort_no_reads", extra_read, 0);
      check("abort_moves", mv, 2);
      check("abort_left", wr_ptr - rd_ptr, 6);
      exp_total = 0;
`ifdef ACTOR_RESPONDER_STATS_EN
      check("abort_tokens_total", tokens_total, 0);
`endif
      @(posedge ap_clk); #1;
      run("after_abort", 0, 1'b1, -1, 6, 8, R_EXEC);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
